// File: rtl/bus_initiator.sv
// bus_initiator: requesting end of a single-cycle addr/data bus with ack timeout
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready         local command handshake (ready only in IDLE)
//   cmd_addr/cmd_wdata/cmd_rw   command fields (rw: 1=write, 0=read)
//   rsp_valid/rsp_rdata/rsp_error  one-cycle response pulse
//   busy                        transaction in flight
//   init_addr_out(_valid)       address pulse toward the target
//   init_data_out(_valid)       write-data pulse toward the target
//   init_rw                     direction, held for the whole transaction
//   init_data_in(_valid)        read data from the target
//   init_ack, init_ready        target acknowledge and address-accept readiness
module bus_initiator #(
    parameter bit SPLIT_WRITE = 1'b0,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic        cmd_rw,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic [15:0] init_addr_out,
    output logic        init_addr_out_valid,
    output logic [7:0]  init_data_out,
    output logic        init_data_out_valid,
    output logic        init_rw,
    input  logic [7:0]  init_data_in,
    input  logic        init_data_in_valid,
    input  logic        init_ack,
    input  logic        init_ready
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, REQ, DATA, WAIT_ACK, RESP} state_t;
    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [15:0]   addr_nx;
    logic [7:0]    data_nx, rdata_nx;
    logic          rw_nx, addr_v_nx, data_v_nx, rsp_v_nx, err_nx;
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    always_comb begin
        state_nx  = state;
        timer_nx  = '0;
        addr_nx   = init_addr_out;
        data_nx   = init_data_out;
        rw_nx     = init_rw;
        addr_v_nx = 1'b0;
        data_v_nx = 1'b0;
        rsp_v_nx  = 1'b0;
        rdata_nx  = 8'h00;
        err_nx    = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                addr_nx  = cmd_addr;
                data_nx  = cmd_wdata;
                rw_nx    = cmd_rw;
                state_nx = REQ;
            end
            REQ: if (init_ready) begin
                addr_v_nx = 1'b1;
                data_v_nx = init_rw && !SPLIT_WRITE;
                state_nx  = (init_rw && SPLIT_WRITE) ? DATA : WAIT_ACK;
            end
            DATA: begin
                data_v_nx = 1'b1;
                state_nx  = WAIT_ACK;
            end
            WAIT_ACK: begin
                // saturating so the counter can never wrap back into range
                timer_nx = (timer == {TW{1'b1}}) ? timer : timer + TW'(1);
                if (init_ack) begin
                    state_nx = RESP;
                    rsp_v_nx = 1'b1;
                    rdata_nx = (init_rw || !init_data_in_valid) ? 8'h00 : init_data_in;
                    err_nx   = !init_rw && !init_data_in_valid;
                end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                    state_nx = RESP;
                    rsp_v_nx = 1'b1;
                    err_nx   = 1'b1;
                end
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            timer               <= '0;
            init_addr_out       <= '0;
            init_data_out       <= '0;
            init_rw             <= 1'b0;
            init_addr_out_valid <= 1'b0;
            init_data_out_valid <= 1'b0;
            rsp_valid           <= 1'b0;
            rsp_rdata           <= '0;
            rsp_error           <= 1'b0;
        end else begin
            state               <= state_nx;
            timer               <= timer_nx;
            init_addr_out       <= addr_nx;
            init_data_out       <= data_nx;
            init_rw             <= rw_nx;
            init_addr_out_valid <= addr_v_nx;
            init_data_out_valid <= data_v_nx;
            rsp_valid           <= rsp_v_nx;
            rsp_rdata           <= rdata_nx;
            rsp_error           <= err_nx;
        end
    end
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: directed vector bench for bus_initiator with both SPLIT_WRITE settings
module tb_bus_initiator;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_rw = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0, init_data_in = '0;
    logic        init_data_in_valid = 1'b0, init_ack = 1'b0, init_ready = 1'b0;
    logic        cmd_ready[2], rsp_valid[2], rsp_error[2], busy[2];
    logic        addr_v[2], data_v[2], init_rw[2];
    logic [7:0]  rsp_rdata[2], init_data_out[2];
    logic [15:0] init_addr_out[2];
    logic [7:0]  mem[256];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    bus_initiator #(.SPLIT_WRITE(1'b0), .ACK_TIMEOUT(15)) u0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_rw(cmd_rw),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]),
        .busy(busy[0]), .init_addr_out(init_addr_out[0]), .init_addr_out_valid(addr_v[0]),
        .init_data_out(init_data_out[0]), .init_data_out_valid(data_v[0]), .init_rw(init_rw[0]),
        .init_data_in(init_data_in), .init_data_in_valid(init_data_in_valid),
        .init_ack(init_ack), .init_ready(init_ready));

    bus_initiator #(.SPLIT_WRITE(1'b1), .ACK_TIMEOUT(15)) u1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_rw(cmd_rw),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]),
        .busy(busy[1]), .init_addr_out(init_addr_out[1]), .init_addr_out_valid(addr_v[1]),
        .init_data_out(init_data_out[1]), .init_data_out_valid(data_v[1]), .init_rw(init_rw[1]),
        .init_data_in(init_data_in), .init_data_in_valid(init_data_in_valid),
        .init_ack(init_ack), .init_ready(init_ready));

    typedef struct {
        int          split;
        bit          rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          rd;     // cycles init_ready is held low in REQ
        int          ack;    // 0 never, 1 ack with data, 2 ack without data_in_valid
        int          e_addr;
        int          e_data;
        int          e_rsp;
        logic [7:0]  e_rdata;
        bit          e_err;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        init_ack = 1'b0;
        init_data_in_valid = 1'b0;
        init_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk({tag, "_cmd_ready"}, cmd_ready[s], 1);
            chk({tag, "_busy"}, busy[s], 0);
            chk({tag, "_rsp_valid"}, rsp_valid[s], 0);
            chk({tag, "_rsp_rdata"}, rsp_rdata[s], 0);
            chk({tag, "_rsp_error"}, rsp_error[s], 0);
            chk({tag, "_addr_valid"}, addr_v[s], 0);
            chk({tag, "_data_valid"}, data_v[s], 0);
            chk({tag, "_addr_out"}, init_addr_out[s], 0);
            chk({tag, "_data_out"}, init_data_out[s], 0);
            chk({tag, "_rw"}, init_rw[s], 0);
        end
    endtask

    // Cycle 0 is the accept cycle; the bench acts as target, acking one cycle after the last pulse.
    task automatic run_vec(input vec_t v, input bit do_rst);
        int s = v.split;
        int pa = -1, pd = -1, pr = -1, last;
        logic [7:0] rd_got = '0;
        logic err_got = 1'b0;
        if (do_rst) reset_dut(); else @(negedge clk);
        chk("accept_ready", cmd_ready[s], 1);
        cmd_valid = 1'b1; cmd_rw = v.rw; cmd_addr = v.addr; cmd_wdata = v.wdata;
        init_ready = 1'b0; init_ack = 1'b0; init_data_in_valid = 1'b0;
        for (int c = 1; c < 60 && pr < 0; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0; init_ack = 1'b0; init_data_in_valid = 1'b0;
            if (addr_v[s] && pa < 0) begin
                pa = c;
                chk("addr_value", init_addr_out[s], v.addr);
                chk("rw_value", init_rw[s], v.rw);
            end
            if (data_v[s] && pd < 0) begin
                pd = c;
                chk("wdata_value", init_data_out[s], v.wdata);
                mem[init_addr_out[s][7:0]] = init_data_out[s];
            end
            if (rsp_valid[s]) begin
                pr = c; rd_got = rsp_rdata[s]; err_got = rsp_error[s];
            end
            last = v.rw ? pd : pa;
            init_ready = (c >= 1 + v.rd);
            if (v.ack != 0 && last >= 0 && c == last + 1) begin
                init_ack = 1'b1;
                init_data_in_valid = (v.ack == 1) && !v.rw;
                init_data_in = mem[v.addr[7:0]];
            end
        end
        chk("addr_cycle", pa, v.e_addr);
        if (v.rw) chk("data_cycle", pd, v.e_data);
        chk("rsp_cycle", pr, v.e_rsp);
        chk("rsp_rdata", rd_got, v.e_rdata);
        chk("rsp_error", err_got, v.e_err);
        @(negedge clk);
        chk("rsp_pulse_end", rsp_valid[s], 0);
        chk("rdata_cleared", rsp_rdata[s], 0);
        chk("idle_after_resp", cmd_ready[s], 1);
    endtask

    initial begin
        int n_rsp, idx, pa, hits;
        bit acc_prev;
        logic [16:0] b2b_cmd[3];
        int          b2b_rsp[3];
        logic [7:0]  b2b_rdata[3];
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        //          split rw addr      wdata  rd ack e_addr e_data e_rsp e_rdata e_err
        vecs[0] = '{0, 1, 16'h0003, 8'h5A, 0,  1,  2,  2,  4,  8'h00, 0};
        vecs[1] = '{0, 0, 16'h0003, 8'h00, 0,  1,  2, -1,  4,  8'h5A, 0};
        vecs[2] = '{1, 1, 16'h0010, 8'hC3, 0,  1,  2,  3,  5,  8'h00, 0};
        vecs[3] = '{1, 0, 16'h0010, 8'h00, 0,  1,  2, -1,  4,  8'hC3, 0};
        vecs[4] = '{0, 0, 16'h0003, 8'h00, 10, 1, 12, -1, 14,  8'h5A, 0};
        vecs[5] = '{0, 0, 16'h0007, 8'h00, 0,  0,  2, -1, 17,  8'h00, 1};
        vecs[6] = '{0, 0, 16'h0003, 8'h00, 0,  2,  2, -1,  4,  8'h00, 1};
        vecs[7] = '{1, 1, 16'h0020, 8'h11, 0,  0,  2,  3, 18,  8'h00, 1};
        vecs[8] = '{0, 1, 16'hFFFF, 8'hA5, 0,  1,  2,  2,  4,  8'h00, 0};

        reset_dut();
        check_idle("reset");

        for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b1);

        // late ack two cycles after a timeout response must be dropped
        run_vec(vecs[5], 1'b1);
        @(negedge clk);
        init_ack = 1'b1; init_data_in_valid = 1'b1; init_data_in = 8'hEE;
        hits = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            init_ack = 1'b0; init_data_in_valid = 1'b0;
            if (rsp_valid[0] || busy[0]) hits++;
        end
        chk("late_ack_ignored", hits, 0);

        // three back-to-back commands with cmd_valid held high
        b2b_cmd[0] = {1'b1, 16'h0040}; b2b_rdata[0] = 8'h00; b2b_rsp[0] = 4;
        b2b_cmd[1] = {1'b0, 16'h0040}; b2b_rdata[1] = 8'h77; b2b_rsp[1] = 9;
        b2b_cmd[2] = {1'b1, 16'h0041}; b2b_rdata[2] = 8'h00; b2b_rsp[2] = 14;
        reset_dut();
        idx = 0; n_rsp = 0; pa = -10; acc_prev = 1'b0;
        init_ready = 1'b1;
        cmd_valid = 1'b1; {cmd_rw, cmd_addr} = b2b_cmd[0]; cmd_wdata = 8'h77;
        for (int c = 0; c < 40 && n_rsp < 3; c++) begin
            if (c > 0) @(negedge clk);
            init_ack = 1'b0; init_data_in_valid = 1'b0;
            if (acc_prev) begin
                idx++;
                if (idx < 3) begin
                    {cmd_rw, cmd_addr} = b2b_cmd[idx];
                    cmd_wdata = 8'h99;
                end else cmd_valid = 1'b0;
            end
            if (addr_v[0]) pa = c;
            if (data_v[0]) mem[init_addr_out[0][7:0]] = init_data_out[0];
            if (rsp_valid[0]) begin
                chk("b2b_rsp_cycle", c, b2b_rsp[n_rsp]);
                chk("b2b_rdata", rsp_rdata[0], b2b_rdata[n_rsp]);
                chk("b2b_error", rsp_error[0], 0);
                n_rsp++;
            end
            acc_prev = cmd_ready[0] && cmd_valid;
            if (acc_prev) chk("b2b_accept_cycle", c, 5 * idx);
            if (c == pa + 1) begin
                init_ack = 1'b1;
                init_data_in_valid = !init_rw[0];
                init_data_in = mem[init_addr_out[0][7:0]];
            end
        end
        chk("b2b_rsp_count", n_rsp, 3);
        cmd_valid = 1'b0;

        // reset asserted during WAIT_ACK aborts silently
        reset_dut();
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 16'h1234; init_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_addr_pulse", addr_v[0], 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("abort");
        hits = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid[0] || rsp_valid[1]) hits++;
        end
        chk("abort_no_rsp", hits, 0);
        run_vec(vecs[1], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
